// File: rtl/motor_emu_pkg.sv
// motor_emu_pkg
//   Shared definitions for the motor/encoder emulator:
//   - meas_state_e : PWM measurement FSM states
//   - dir_e        : H-bridge direction decoded from {in1, in2}
//   - QUAD_S0..S3  : quadrature output sequence {enc_a, enc_b} in forward order
//   - dir_decode() : {in1, in2} -> dir_e
//   - quad_next()  : next quadrature state for one step in the given direction
package motor_emu_pkg;

   typedef enum logic {
      StIdle,
      StRun
   } meas_state_e;

   // Encoded as {in1, in2} for the two driving combinations; anything else brakes.
   typedef enum logic [1:0] {
      DirBrake = 2'b00,
      DirRev   = 2'b01,
      DirFwd   = 2'b10
   } dir_e;

   // Forward order: S0 -> S1 -> S2 -> S3 -> S0, one bit changes per step.
   localparam logic [1:0] QUAD_S0 = 2'b00;
   localparam logic [1:0] QUAD_S1 = 2'b10;
   localparam logic [1:0] QUAD_S2 = 2'b11;
   localparam logic [1:0] QUAD_S3 = 2'b01;

   function automatic dir_e dir_decode(input logic in1, input logic in2);
      case ({in1, in2})
         2'b10:   return DirFwd;
         2'b01:   return DirRev;
         default: return DirBrake;
      endcase
   endfunction

   function automatic logic [1:0] quad_next(input logic [1:0] cur, input logic fwd);
      case (cur)
         QUAD_S0: return fwd ? QUAD_S1 : QUAD_S3;
         QUAD_S1: return fwd ? QUAD_S2 : QUAD_S0;
         QUAD_S2: return fwd ? QUAD_S3 : QUAD_S1;
         default: return fwd ? QUAD_S0 : QUAD_S2;
      endcase
   endfunction

endpackage

// File: rtl/motor_emu_channel.sv
// motor_emu_channel
//   One motor/encoder channel: measures the PWM duty (high cycles per period),
//   turns it into a speed reduced by the load drag, integrates the speed in a
//   phase accumulator and emits one quadrature step per accumulator carry.
//   Optional macro ENC_INDEX_EN adds a position counter (0..CPR-1) and o_enc_z.
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_pwm              motor enable PWM
//   i_in1, i_in2       direction pins (10 fwd, 01 rev, equal = brake)
//   i_drag             load drag subtracted from the measured duty
//   o_enc_a, o_enc_b   quadrature outputs
//   o_enc_z            index pulse (ENC_INDEX_EN only)
//   o_duty_meas        last measured duty
//   o_meas_valid       1-cycle strobe when o_duty_meas is updated
module motor_emu_channel #(
   parameter int unsigned DUTY_W  = 7,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned THRESH  = 5,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CPR     = 48
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_pwm,
   input  logic              i_in1,
   input  logic              i_in2,
   input  logic [DUTY_W-1:0] i_drag,
   output logic              o_enc_a,
   output logic              o_enc_b,
`ifdef ENC_INDEX_EN
   output logic              o_enc_z,
`endif
   output logic [DUTY_W-1:0] o_duty_meas,
   output logic              o_meas_valid
);
   import motor_emu_pkg::*;

   localparam int unsigned       TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
   localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

   if (ACC_W <= DUTY_W || CPR < 2 || TIMEOUT < 1) begin : g_bad_params
      $error("motor_emu_channel: need ACC_W > DUTY_W, CPR >= 2, TIMEOUT >= 1");
   end

   logic                r_pwm_q;
   meas_state_e         r_state;
   logic [DUTY_W-1:0]   r_high_cnt;
   logic [TO_W-1:0]     r_edge_cnt;
   logic [DUTY_W-1:0]   r_duty_meas;
   logic                r_meas_valid;
   logic [DUTY_W-1:0]   r_speed;
   logic [ACC_W-1:0]    r_acc;
   logic [1:0]          r_quad;

   logic                w_rise;
   logic                w_fall;
   logic                w_edge;
   dir_e                w_dir;
   logic [ACC_W:0]      w_acc_sum;
   logic                w_step;
   logic [DUTY_W-1:0]   w_speed_next;

   assign w_rise    = i_pwm & ~r_pwm_q;
   assign w_fall    = ~i_pwm & r_pwm_q;
   assign w_edge    = w_rise | w_fall;
   assign w_dir     = dir_decode(i_in1, i_in2);
   assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W + 1 - DUTY_W){1'b0}}, r_speed};
   // Carry out of the accumulator is the step request; braking suppresses it.
   assign w_step    = (w_dir != DirBrake) & w_acc_sum[ACC_W];

   // Low duties stall the motor; drag never wraps the speed below zero.
   always_comb begin
      w_speed_next = '0;
      if (r_duty_meas > DUTY_W'(THRESH) && r_duty_meas > i_drag) begin
         w_speed_next = r_duty_meas - i_drag;
      end
   end

   // Measurement FSM. The edge counter saturates; it only matters in StRun,
   // which is always entered through a rise that clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pwm_q      <= 1'b0;
         r_state      <= StIdle;
         r_high_cnt   <= '0;
         r_edge_cnt   <= '0;
         r_duty_meas  <= '0;
         r_meas_valid <= 1'b0;
      end else begin
         r_pwm_q      <= i_pwm;
         r_meas_valid <= 1'b0;
         if (w_edge) begin
            r_edge_cnt <= '0;
         end else if (r_edge_cnt != TO_MAX) begin
            r_edge_cnt <= r_edge_cnt + TO_W'(1);
         end
         case (r_state)
            StIdle: begin
               if (w_rise) begin
                  r_state    <= StRun;
                  r_high_cnt <= DUTY_W'(1);
               end
            end
            StRun: begin
               if (w_rise) begin
                  r_duty_meas  <= r_high_cnt;
                  r_meas_valid <= 1'b1;
                  r_high_cnt   <= DUTY_W'(1);
               end else if (!w_edge && r_edge_cnt == TO_MAX) begin
                  // Static PWM: report the held level as 0% or 100%.
                  r_duty_meas  <= r_pwm_q ? DUTY_MAX : '0;
                  r_meas_valid <= 1'b1;
                  r_state      <= StIdle;
                  r_high_cnt   <= '0;
               end else if (i_pwm && r_high_cnt != DUTY_MAX) begin
                  r_high_cnt <= r_high_cnt + DUTY_W'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_speed <= '0;
         r_acc   <= '0;
         r_quad  <= QUAD_S0;
      end else begin
         if (r_meas_valid) begin
            r_speed <= w_speed_next;
         end
         if (w_dir != DirBrake) begin
            r_acc <= w_acc_sum[ACC_W-1:0];
         end
         if (w_step) begin
            r_quad <= quad_next(r_quad, w_dir == DirFwd);
         end
      end
   end

`ifdef ENC_INDEX_EN
   localparam int unsigned POS_W = $clog2(CPR);

   logic [POS_W-1:0] r_pos;
   logic             r_enc_z;
   logic [POS_W-1:0] w_pos_next;

   always_comb begin
      w_pos_next = r_pos;
      if (w_dir == DirFwd) begin
         w_pos_next = (r_pos == POS_W'(CPR - 1)) ? '0 : r_pos + POS_W'(1);
      end else if (w_dir == DirRev) begin
         w_pos_next = (r_pos == '0) ? POS_W'(CPR - 1) : r_pos - POS_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pos   <= '0;
         r_enc_z <= 1'b0;
      end else begin
         if (w_step) begin
            r_pos <= w_pos_next;
         end
         r_enc_z <= w_step && (w_pos_next == '0);
      end
   end

   assign o_enc_z = r_enc_z;
`endif

   assign o_enc_a      = r_quad[1];
   assign o_enc_b      = r_quad[0];
   assign o_duty_meas  = r_duty_meas;
   assign o_meas_valid = r_meas_valid;

endmodule

// File: rtl/motor_enc_emulator.sv
// motor_enc_emulator
//   NUM_CH independent L298N-driven motor models with quadrature encoder
//   outputs. Each channel measures its PWM duty, derives a speed after load
//   drag and produces quadrature steps at that rate.
//   Optional macro ENC_INDEX_EN adds a per-channel index output enc_z.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pwm, in1, in2       per-channel PWM and direction pins
//   drag                per-channel drag, channel n at [n*DUTY_W +: DUTY_W]
//   enc_a, enc_b        per-channel quadrature outputs
//   enc_z               per-channel index pulse (ENC_INDEX_EN only)
//   duty_meas           per-channel last measured duty
//   meas_valid          per-channel measurement strobe
module motor_enc_emulator #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned DUTY_W  = 7,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned THRESH  = 5,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CPR     = 48
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          pwm,
   input  logic [NUM_CH-1:0]          in1,
   input  logic [NUM_CH-1:0]          in2,
   input  logic [NUM_CH*DUTY_W-1:0]   drag,
   output logic [NUM_CH-1:0]          enc_a,
   output logic [NUM_CH-1:0]          enc_b,
`ifdef ENC_INDEX_EN
   output logic [NUM_CH-1:0]          enc_z,
`endif
   output logic [NUM_CH*DUTY_W-1:0]   duty_meas,
   output logic [NUM_CH-1:0]          meas_valid
);

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      motor_emu_channel #(
         .DUTY_W  (DUTY_W),
         .ACC_W   (ACC_W),
         .THRESH  (THRESH),
         .TIMEOUT (TIMEOUT),
         .CPR     (CPR)
      ) u_ch (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_pwm        (pwm[g]),
         .i_in1        (in1[g]),
         .i_in2        (in2[g]),
         .i_drag       (drag[g*DUTY_W +: DUTY_W]),
         .o_enc_a      (enc_a[g]),
         .o_enc_b      (enc_b[g]),
`ifdef ENC_INDEX_EN
         .o_enc_z      (enc_z[g]),
`endif
         .o_duty_meas  (duty_meas[g*DUTY_W +: DUTY_W]),
         .o_meas_valid (meas_valid[g])
      );
   end

endmodule

// File: tb/tb_motor_enc_emulator.sv
// tb_motor_enc_emulator
//   Directed bench for motor_enc_emulator (NUM_CH=2, DUTY_W=7, ACC_W=8,
//   TIMEOUT=255, CPR=8). Channel 0 is exercised; channel 1 stays idle.
//   Index checks are compiled in when ENC_INDEX_EN is defined.
module tb_motor_enc_emulator;

   localparam int DW = 7;

   logic             clk;
   logic             rst;
   logic [1:0]       pwm;
   logic [1:0]       in1;
   logic [1:0]       in2;
   logic [2*DW-1:0]  drag;
   logic [1:0]       enc_a;
   logic [1:0]       enc_b;
`ifdef ENC_INDEX_EN
   logic [1:0]       enc_z;
`endif
   logic [2*DW-1:0]  duty_meas;
   logic [1:0]       meas_valid;

   motor_enc_emulator #(
      .NUM_CH  (2),
      .DUTY_W  (DW),
      .ACC_W   (8),
      .THRESH  (5),
      .TIMEOUT (255),
      .CPR     (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm        (pwm),
      .in1        (in1),
      .in2        (in2),
      .drag       (drag),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
`ifdef ENC_INDEX_EN
      .enc_z      (enc_z),
`endif
      .duty_meas  (duty_meas),
      .meas_valid (meas_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Bench-side quadrature model: forward 00 -> 10 -> 11 -> 01 -> 00.
   function automatic logic [1:0] fwd_of(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_of(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Output monitor, sampled 2 time units after each rising clock edge.
   int         n_fwd = 0;
   int         n_rev = 0;
   int         n_bad = 0;
   int         n_mv0 = 0;
   int         n_ch1 = 0;
   int         n_z = 0;
   int         n_zhigh = 0;
   logic [1:0] prev0 = 2'b00;
   logic [1:0] cur0;
   logic [1:0] first_chg = 2'b00;
   bit         got_first = 1'b0;
   logic       prev_z = 1'b0;

   always @(posedge clk) begin
      #2;
      cur0 = {enc_a[0], enc_b[0]};
      if (rst) begin
         prev0 = 2'b00;
      end else if (cur0 != prev0) begin
         if (cur0 == fwd_of(prev0))      n_fwd++;
         else if (cur0 == rev_of(prev0)) n_rev++;
         else                            n_bad++;
         if (!got_first) begin
            got_first = 1'b1;
            first_chg = cur0;
         end
         prev0 = cur0;
      end
      if (meas_valid[0] === 1'b1) n_mv0++;
      if (meas_valid[1] !== 1'b0 || enc_a[1] !== 1'b0 || enc_b[1] !== 1'b0 ||
          duty_meas[2*DW-1:DW] !== '0) n_ch1++;
`ifdef ENC_INDEX_EN
      if (enc_z[1] !== 1'b0) n_ch1++;
      if (enc_z[0] === 1'b1) n_zhigh++;
      if (enc_z[0] === 1'b1 && !prev_z) n_z++;
      prev_z = enc_z[0];
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      pwm[0] = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic period(input int hi, input int lo);
      drive(1'b1, hi);
      drive(1'b0, lo);
   endtask

   function automatic int steps();
      return n_fwd + n_rev + n_bad;
   endfunction

   int         f0, r0, s0, m0, z0, zh0;
   logic [1:0] enc_snap;

   initial begin
      rst  = 1'b1;
      pwm  = 2'b00;
      in1  = 2'b01;
      in2  = 2'b00;
      drag = '0;
      repeat (3) @(negedge clk);
      chk("rst_enc0", {30'd0, enc_a[0], enc_b[0]}, 0);
      chk("rst_duty", {18'd0, duty_meas}, 0);
      chk("rst_mv", {30'd0, meas_valid}, 0);
      rst = 1'b0;

      // 64/128 PWM, drag 0: first rise only arms, second measures 64.
      period(64, 64);
      chk("arm_no_mv", n_mv0, 0);
      period(64, 64);
      chk("mv_after_2nd_rise", n_mv0, 1);
      chk("duty_64", {25'd0, duty_meas[DW-1:0]}, 64);
      chk("first_step_10", {30'd0, first_chg}, 2'b10);

      f0 = n_fwd; r0 = n_rev; s0 = n_bad; m0 = n_mv0; z0 = n_z; zh0 = n_zhigh;
      period(64, 64);
      chk("speed64_fwd_steps", n_fwd - f0, 32);
      chk("speed64_rev_steps", n_rev - r0, 0);
      chk("speed64_bad_steps", n_bad - s0, 0);
      chk("mv_once_per_period", n_mv0 - m0, 1);
`ifdef ENC_INDEX_EN
      chk("index_pulses", n_z - z0, 4);
      chk("index_width", n_zhigh - zh0, 4);
`endif

      // Drag above duty stalls the motor.
      drag[DW-1:0] = 7'd80;
      period(64, 64);
      f0 = steps(); enc_snap = {enc_a[0], enc_b[0]};
      period(64, 64);
      chk("drag80_no_steps", steps() - f0, 0);
      chk("drag80_static", {30'd0, enc_a[0], enc_b[0]}, {30'd0, enc_snap});

      // Drag 16 -> speed 48: 3 steps per 16 cycles, 24 per period.
      drag[DW-1:0] = 7'd16;
      period(64, 64);
      f0 = n_fwd;
      drive(1'b1, 16);
      chk("speed48_16cyc", n_fwd - f0, 3);
      drive(1'b1, 48);
      drive(1'b0, 64);
      chk("speed48_period", n_fwd - f0, 24);
      chk("duty_still_64", {25'd0, duty_meas[DW-1:0]}, 64);

      // Reverse mid-run, then brake.
      in1[0] = 1'b0; in2[0] = 1'b1;
      f0 = n_fwd; r0 = n_rev; s0 = n_bad;
      drive(1'b1, 16);
      chk("rev_steps", n_rev - r0, 3);
      chk("rev_no_fwd", n_fwd - f0, 0);
      chk("rev_no_skip", n_bad - s0, 0);
      in1[0] = 1'b1; in2[0] = 1'b1;
      f0 = steps(); enc_snap = {enc_a[0], enc_b[0]};
      m0 = n_mv0;
      drive(1'b1, 48);
      drive(1'b0, 64);
      chk("brake_no_steps", steps() - f0, 0);
      chk("brake_static", {30'd0, enc_a[0], enc_b[0]}, {30'd0, enc_snap});

      // pwm held low: strobe with duty 0 exactly 256 cycles after the fall.
      in1[0] = 1'b1; in2[0] = 1'b0;
      drive(1'b0, 192);
      chk("low_no_mv_at_255", n_mv0 - m0, 0);
      drive(1'b0, 1);
      chk("low_mv_at_256", {31'd0, meas_valid[0]}, 1);
      chk("low_duty_0", {25'd0, duty_meas[DW-1:0]}, 0);
      drive(1'b0, 43);
      chk("low_single_mv", n_mv0 - m0, 1);

      // pwm held high: duty reported as 127.
      m0 = n_mv0;
      drive(1'b1, 256);
      chk("high_no_mv_at_255", n_mv0 - m0, 0);
      drive(1'b1, 1);
      chk("high_mv_at_256", {31'd0, meas_valid[0]}, 1);
      chk("high_duty_127", {25'd0, duty_meas[DW-1:0]}, 127);
      drive(1'b1, 43);

      // Threshold: duty 5 stalls, duty 6 gives speed 6 (3 steps per 128).
      drag[DW-1:0] = 7'd0;
      drive(1'b0, 64);
      period(5, 123);
      period(5, 123);
      f0 = n_fwd;
      period(5, 123);
      chk("thresh5_no_steps", n_fwd - f0, 0);
      chk("duty_5", {25'd0, duty_meas[DW-1:0]}, 5);
      period(6, 122);
      period(6, 122);
      f0 = n_fwd;
      period(6, 122);
      chk("duty6_steps", n_fwd - f0, 3);
      chk("duty_6", {25'd0, duty_meas[DW-1:0]}, 6);

      // Reset mid-period: immediate clear, measurement restarts from scratch.
      drive(1'b1, 32);
      rst = 1'b1;
      #1;
      chk("midrst_enc", {30'd0, enc_a[0], enc_b[0]}, 0);
      chk("midrst_duty", {18'd0, duty_meas}, 0);
      chk("midrst_mv", {30'd0, meas_valid}, 0);
      drive(1'b1, 32);
      drive(1'b0, 10);
      rst = 1'b0;
      m0 = n_mv0; f0 = steps();
      drive(1'b0, 54);
      period(64, 64);
      chk("postrst_first_rise_no_mv", n_mv0 - m0, 0);
      chk("postrst_no_steps", steps() - f0, 0);
      drive(1'b1, 1);
      chk("postrst_mv_2nd_rise", {31'd0, meas_valid[0]}, 1);
      chk("postrst_duty_64", {25'd0, duty_meas[DW-1:0]}, 64);
      drive(1'b1, 63);
      drive(1'b0, 64);

      chk("never_bad_step", n_bad, 0);
      chk("ch1_idle", n_ch1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/motor_enc_emulator.md
MOTOR_ENC_EMULATOR -- requirements
Module: motor_enc_emulator

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of independent motor/encoder channels.
REQ-002 The block SHALL have parameter DUTY_W, default 7, width of duty count, drag and speed.
REQ-003 The block SHALL have parameter ACC_W, default 16, width of each channel's step phase accumulator (ACC_W > DUTY_W).
REQ-004 The block SHALL have parameter THRESH, default 5, duty at or below which the motor is stopped.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, cycles without any pwm edge before a static-level measurement.
REQ-006 The block SHALL have parameter CPR, default 48, quadrature steps per revolution, used only for the index output.
REQ-007 The block SHALL have port clk  input  1  master PWM sample clock; one clock only.
REQ-008 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-009 The block SHALL have port pwm  input  NUM_CH  per-channel motor enable PWM.
REQ-010 The block SHALL have ports in1, in2  input  NUM_CH each  per-channel L298N direction pins.
REQ-011 The block SHALL have port drag  input  NUM_CH*DUTY_W  per-channel load drag, channel n at bits [n*DUTY_W +: DUTY_W].
REQ-012 The block SHALL have ports enc_a, enc_b  output  NUM_CH each  quadrature encoder channels.
REQ-013 The block SHALL have port enc_z  output  NUM_CH  index pulse, present only with ENC_INDEX_EN.
REQ-014 The block SHALL have ports duty_meas  output  NUM_CH*DUTY_W  and meas_valid  output  NUM_CH, giving the last measured duty and a 1-cycle strobe.

Function
REQ-015 Each channel SHALL register pwm once (pwm_q); rise = pwm & ~pwm_q, fall = ~pwm & pwm_q.
REQ-016 The measurement FSM SHALL have states IDLE (await first rise) and RUN (measuring).
REQ-017 IDLE on rise: go to RUN, high_cnt <= 1, no strobe.
REQ-018 RUN: high_cnt += 1 each cycle pwm is high, saturating at 2^DUTY_W-1.
REQ-019 RUN on rise: duty_meas <= high_cnt, meas_valid pulses 1 cycle, high_cnt <= 1, stay in RUN.
REQ-020 Edge counter SHALL clear on any edge; at TIMEOUT: duty_meas <= pwm_q ? 2^DUTY_W-1 : 0, meas_valid pulses, FSM -> IDLE, high_cnt <= 0.
REQ-021 On the cycle after meas_valid, speed SHALL be 0 if duty_meas <= THRESH, else max(duty_meas - drag, 0) (no wrap).
REQ-022 Direction: in1=1,in2=0 forward; in1=0,in2=1 reverse; in1==in2 brake: effective speed 0, accumulator holds.
REQ-023 Each cycle not braking, acc <= acc + speed (ACC_W bits); the carry-out SHALL produce exactly one quadrature step that cycle.
REQ-024 Forward: {enc_a,enc_b} SHALL follow 00->10->11->01->00; reverse follows the opposite order; exactly one bit changes per step.
REQ-025 A direction change SHALL apply from the next step with no skipped or double transitions; speed 0 SHALL hold outputs static.
REQ-026 Channels SHALL be fully independent; no cross-channel state.

Reset
REQ-027 rst SHALL clear: FSM IDLE, all counters, acc, speed, duty_meas 0, meas_valid 0, {enc_a,enc_b} 00, enc_z 0, position 0.
REQ-028 rst mid-measurement SHALL discard the partial count; no meas_valid until the second rise after release.

Configuration
REQ-029 With macro ENC_INDEX_EN defined, a position counter SHALL count 0..CPR-1 (+1 forward, -1 reverse, wrapping), and enc_z SHALL be high for the cycle after any step that lands on position 0.
REQ-030 Without ENC_INDEX_EN, enc_z and the position counter SHALL not exist.

Structure
REQ-031 Package motor_emu_pkg SHALL hold the FSM state encoding, the 2-bit quadrature sequence constants and the direction encoding.
REQ-032 Per-channel logic SHALL be sub-module motor_emu_channel, instantiated NUM_CH times by a generate loop.

Verification (NUM_CH=2, DUTY_W=7, ACC_W=8, TIMEOUT=255, CPR=8)
REQ-033 Bench: ch0 pwm 64 high / 128 period, drag 0, in1=1,in2=0 -> duty_meas 64 once per period; one step per 4 cycles, sequence 00,10,11,01.
REQ-034 Bench: same, drag 80 -> speed 0, outputs static; drag 16 -> one step per 16/3 cycles average (3 steps per 16 cycles).
REQ-035 Bench: pwm held low 300 cycles -> meas_valid with duty_meas 0 at 256 cycles after last edge; held high -> duty_meas 127.
REQ-036 Bench: mid-run in1/in2 flip to 0/1 -> next step reverses order (e.g., 11->10), no skipped state; 1/1 -> outputs freeze.
REQ-037 Bench: ENC_INDEX_EN, forward speed 64 -> enc_z 1-cycle pulse every 32 cycles; ch1 idle throughout -> ch1 outputs 00.
REQ-038 Bench: rst asserted mid-period -> all outputs 0 immediately; first meas_valid only after two rises following release.
